// File: rtl/id_ex_skid_stage_pkg.sv
// Shared pipeline header for the decode/execute stage registers.
// Holds the packed control bundle layout (field offsets and widths), the
// default bundle width, and small helpers to build and inspect a bundle.
// Bundle layout, MSB to LSB: rf_wsel[1:0], branch[2:0], rf_we, alu_op[3:0],
// alub_sel, ram_we.
package id_ex_skid_stage_pkg;

    localparam int RAM_WE_OFF   = 0;
    localparam int RAM_WE_W     = 1;
    localparam int ALUB_SEL_OFF = 1;
    localparam int ALUB_SEL_W   = 1;
    localparam int ALU_OP_OFF   = 2;
    localparam int ALU_OP_W     = 4;
    localparam int RF_WE_OFF    = 6;
    localparam int RF_WE_W      = 1;
    localparam int BRANCH_OFF   = 7;
    localparam int BRANCH_W     = 3;
    localparam int RF_WSEL_OFF  = 10;
    localparam int RF_WSEL_W    = 2;

    localparam int CTRL_W_DEF   = RF_WSEL_OFF + RF_WSEL_W;

    // Assemble a control bundle from its fields.
    function automatic logic [CTRL_W_DEF-1:0] ctrl_pack(
        input logic [RF_WSEL_W-1:0]  rf_wsel,
        input logic [BRANCH_W-1:0]   branch,
        input logic [RF_WE_W-1:0]    rf_we,
        input logic [ALU_OP_W-1:0]   alu_op,
        input logic [ALUB_SEL_W-1:0] alub_sel,
        input logic [RAM_WE_W-1:0]   ram_we
    );
        logic [CTRL_W_DEF-1:0] c;
        c = {CTRL_W_DEF{1'b0}};
        c[RF_WSEL_OFF  +: RF_WSEL_W]  = rf_wsel;
        c[BRANCH_OFF   +: BRANCH_W]   = branch;
        c[RF_WE_OFF    +: RF_WE_W]    = rf_we;
        c[ALU_OP_OFF   +: ALU_OP_W]   = alu_op;
        c[ALUB_SEL_OFF +: ALUB_SEL_W] = alub_sel;
        c[RAM_WE_OFF   +: RAM_WE_W]   = ram_we;
        return c;
    endfunction

    // True when the bundle would write architectural state.
    function automatic logic ctrl_writes(input logic [CTRL_W_DEF-1:0] c);
        return c[RF_WE_OFF] | c[RAM_WE_OFF];
    endfunction

endpackage

// File: rtl/id_ex_skid_stage_if.sv
// Handshake and payload bundle between decode, the ID/EX stage and execute.
// master: the surrounding pipeline (drives instruction, flush, out_ready).
// slave:  the stage itself (drives in_ready, registered outputs, occupancy).
interface id_ex_skid_stage_if
    import id_ex_skid_stage_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int NUM_OPS = 2,
    parameter int REG_AW  = 5,
    parameter int CTRL_W  = CTRL_W_DEF
);
    logic                      in_valid;
    logic                      in_ready;
    logic [DATA_W-1:0]         in_pc;
    logic [DATA_W-1:0]         in_pc4;
    logic [DATA_W-1:0]         in_imm;
    logic [REG_AW-1:0]         in_wr;
    logic [NUM_OPS*DATA_W-1:0] in_ops;
    logic [NUM_OPS-1:0]        fwd_en;
    logic [NUM_OPS*DATA_W-1:0] fwd_data;
    logic [CTRL_W-1:0]         in_ctrl;
    logic                      flush;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_W-1:0]         out_pc;
    logic [DATA_W-1:0]         out_pc4;
    logic [DATA_W-1:0]         out_imm;
    logic [REG_AW-1:0]         out_wr;
    logic [NUM_OPS*DATA_W-1:0] out_ops;
    logic [CTRL_W-1:0]         out_ctrl;
    logic [1:0]                occupancy;

    modport master (
        output in_valid, in_pc, in_pc4, in_imm, in_wr, in_ops, fwd_en,
               fwd_data, in_ctrl, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_pc4, out_imm, out_wr,
               out_ops, out_ctrl, occupancy
    );

    modport slave (
        input  in_valid, in_pc, in_pc4, in_imm, in_wr, in_ops, fwd_en,
               fwd_data, in_ctrl, flush, out_ready,
        output in_ready, out_valid, out_pc, out_pc4, out_imm, out_wr,
               out_ops, out_ctrl, occupancy
    );

endinterface

// File: rtl/id_ex_skid_stage_entry.sv
// One instruction entry of the ID/EX stage (used for both main and skid).
// Ports: clk, rst_n; load captures d_*; clr zeroes ctrl and wr (kills the
// instruction's side effects) while the data fields hold; q_* are the held
// fields. clr wins over load.
module id_ex_skid_stage_entry #(
    parameter int DATA_W  = 32,
    parameter int NUM_OPS = 2,
    parameter int REG_AW  = 5,
    parameter int CTRL_W  = 12
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic                      clr,
    input  logic [DATA_W-1:0]         d_pc,
    input  logic [DATA_W-1:0]         d_pc4,
    input  logic [DATA_W-1:0]         d_imm,
    input  logic [REG_AW-1:0]         d_wr,
    input  logic [NUM_OPS*DATA_W-1:0] d_ops,
    input  logic [CTRL_W-1:0]         d_ctrl,
    output logic [DATA_W-1:0]         q_pc,
    output logic [DATA_W-1:0]         q_pc4,
    output logic [DATA_W-1:0]         q_imm,
    output logic [REG_AW-1:0]         q_wr,
    output logic [NUM_OPS*DATA_W-1:0] q_ops,
    output logic [CTRL_W-1:0]         q_ctrl
);

    logic [DATA_W-1:0]         pc_r;
    logic [DATA_W-1:0]         pc4_r;
    logic [DATA_W-1:0]         imm_r;
    logic [REG_AW-1:0]         wr_r;
    logic [NUM_OPS*DATA_W-1:0] ops_r;
    logic [CTRL_W-1:0]         ctrl_r;

    // Entry storage: clear kills side effects, load captures, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r   <= {DATA_W{1'b0}};
            pc4_r  <= {DATA_W{1'b0}};
            imm_r  <= {DATA_W{1'b0}};
            wr_r   <= {REG_AW{1'b0}};
            ops_r  <= {(NUM_OPS*DATA_W){1'b0}};
            ctrl_r <= {CTRL_W{1'b0}};
        end else if (clr) begin
            wr_r   <= {REG_AW{1'b0}};
            ctrl_r <= {CTRL_W{1'b0}};
        end else if (load) begin
            pc_r   <= d_pc;
            pc4_r  <= d_pc4;
            imm_r  <= d_imm;
            wr_r   <= d_wr;
            ops_r  <= d_ops;
            ctrl_r <= d_ctrl;
        end else begin
            pc_r   <= pc_r;
            pc4_r  <= pc4_r;
            imm_r  <= imm_r;
            wr_r   <= wr_r;
            ops_r  <= ops_r;
            ctrl_r <= ctrl_r;
        end
    end

    assign q_pc   = pc_r;
    assign q_pc4  = pc4_r;
    assign q_imm  = imm_r;
    assign q_wr   = wr_r;
    assign q_ops  = ops_r;
    assign q_ctrl = ctrl_r;

endmodule

// File: rtl/id_ex_skid_stage.sv
// ID/EX pipeline stage: valid/ready register with optional two-entry skid
// buffer, per-operand forwarding override at capture, and flush.
// Ports: clk, rst_n (async, active low), bus (slave side of
// id_ex_skid_stage_if: in_* / fwd_* / flush from decode, out_* / occupancy
// to execute, in_ready / out_ready handshakes).
// SKID=1: in_ready is the registered "skid empty" flag, so decode never
// sees a combinational path from execute. SKID=0: single entry, in_ready
// is combinational from out_ready.
module id_ex_skid_stage
    import id_ex_skid_stage_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int NUM_OPS = 2,
    parameter int REG_AW  = 5,
    parameter int CTRL_W  = CTRL_W_DEF,
    parameter int SKID    = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    id_ex_skid_stage_if.slave  bus
);

    localparam int OPS_W = NUM_OPS * DATA_W;

    logic              main_valid_r;
    logic              skid_valid_r;
    logic              main_valid_nxt_s;
    logic              skid_valid_nxt_s;
    logic              accept_s;
    logic              consume_s;
    logic              main_free_s;
    logic              in_ready_s;
    logic              main_load_s;
    logic              take_skid_s;
    logic [OPS_W-1:0]  cap_ops_s;

    logic [DATA_W-1:0] skid_pc_s;
    logic [DATA_W-1:0] skid_pc4_s;
    logic [DATA_W-1:0] skid_imm_s;
    logic [REG_AW-1:0] skid_wr_s;
    logic [OPS_W-1:0]  skid_ops_s;
    logic [CTRL_W-1:0] skid_ctrl_s;

    logic [DATA_W-1:0] main_d_pc_s;
    logic [DATA_W-1:0] main_d_pc4_s;
    logic [DATA_W-1:0] main_d_imm_s;
    logic [REG_AW-1:0] main_d_wr_s;
    logic [OPS_W-1:0]  main_d_ops_s;
    logic [CTRL_W-1:0] main_d_ctrl_s;

    // Forward override per channel, sampled only when the entry loads.
    for (genvar k = 0; k < NUM_OPS; k++) begin : g_fwd
        assign cap_ops_s[k*DATA_W +: DATA_W] = bus.fwd_en[k]
                                             ? bus.fwd_data[k*DATA_W +: DATA_W]
                                             : bus.in_ops[k*DATA_W +: DATA_W];
    end

    if (SKID != 0) begin : g_ready_skid
        assign in_ready_s = ~skid_valid_r;
    end else begin : g_ready_direct
        assign in_ready_s = ~main_valid_r | bus.out_ready;
    end

    assign accept_s    = bus.in_valid & in_ready_s;
    assign consume_s   = main_valid_r & bus.out_ready;
    assign main_free_s = ~main_valid_r | bus.out_ready;

    // Next-state of both entries; flush outranks accept and skid transfer.
    always_comb begin
        main_valid_nxt_s = main_valid_r;
        skid_valid_nxt_s = skid_valid_r;
        main_load_s      = 1'b0;
        take_skid_s      = 1'b0;
        if (bus.flush) begin
            main_valid_nxt_s = 1'b0;
            skid_valid_nxt_s = 1'b0;
        end else if (skid_valid_r) begin
            // in_ready is low here, so only the skid-to-main move can happen.
            if (consume_s) begin
                take_skid_s      = 1'b1;
                main_load_s      = 1'b1;
                main_valid_nxt_s = 1'b1;
                skid_valid_nxt_s = 1'b0;
            end else begin
                main_valid_nxt_s = main_valid_r;
            end
        end else if (main_free_s) begin
            if (accept_s) begin
                main_load_s      = 1'b1;
                main_valid_nxt_s = 1'b1;
            end else begin
                main_valid_nxt_s = 1'b0;
            end
        end else begin
            // Main full and stalled: an accept can only land in the skid.
            if (accept_s) begin
                skid_valid_nxt_s = 1'b1;
            end else begin
                skid_valid_nxt_s = skid_valid_r;
            end
        end
    end

    // Entry valid flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
        end else begin
            main_valid_r <= main_valid_nxt_s;
            skid_valid_r <= (SKID != 0) ? skid_valid_nxt_s : 1'b0;
        end
    end

    assign main_d_pc_s   = take_skid_s ? skid_pc_s   : bus.in_pc;
    assign main_d_pc4_s  = take_skid_s ? skid_pc4_s  : bus.in_pc4;
    assign main_d_imm_s  = take_skid_s ? skid_imm_s  : bus.in_imm;
    assign main_d_wr_s   = take_skid_s ? skid_wr_s   : bus.in_wr;
    assign main_d_ops_s  = take_skid_s ? skid_ops_s  : cap_ops_s;
    assign main_d_ctrl_s = take_skid_s ? skid_ctrl_s : bus.in_ctrl;

    id_ex_skid_stage_entry #(
        .DATA_W (DATA_W),
        .NUM_OPS(NUM_OPS),
        .REG_AW (REG_AW),
        .CTRL_W (CTRL_W)
    ) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (main_load_s),
        .clr   (bus.flush),
        .d_pc  (main_d_pc_s),
        .d_pc4 (main_d_pc4_s),
        .d_imm (main_d_imm_s),
        .d_wr  (main_d_wr_s),
        .d_ops (main_d_ops_s),
        .d_ctrl(main_d_ctrl_s),
        .q_pc  (bus.out_pc),
        .q_pc4 (bus.out_pc4),
        .q_imm (bus.out_imm),
        .q_wr  (bus.out_wr),
        .q_ops (bus.out_ops),
        .q_ctrl(bus.out_ctrl)
    );

    if (SKID != 0) begin : g_skid
        logic skid_load_s;

        // The skid is written only when it was empty, never overwritten.
        assign skid_load_s = skid_valid_nxt_s & ~skid_valid_r & ~bus.flush;

        id_ex_skid_stage_entry #(
            .DATA_W (DATA_W),
            .NUM_OPS(NUM_OPS),
            .REG_AW (REG_AW),
            .CTRL_W (CTRL_W)
        ) u_skid (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (skid_load_s),
            .clr   (bus.flush),
            .d_pc  (bus.in_pc),
            .d_pc4 (bus.in_pc4),
            .d_imm (bus.in_imm),
            .d_wr  (bus.in_wr),
            .d_ops (cap_ops_s),
            .d_ctrl(bus.in_ctrl),
            .q_pc  (skid_pc_s),
            .q_pc4 (skid_pc4_s),
            .q_imm (skid_imm_s),
            .q_wr  (skid_wr_s),
            .q_ops (skid_ops_s),
            .q_ctrl(skid_ctrl_s)
        );
    end else begin : g_no_skid
        assign skid_pc_s   = {DATA_W{1'b0}};
        assign skid_pc4_s  = {DATA_W{1'b0}};
        assign skid_imm_s  = {DATA_W{1'b0}};
        assign skid_wr_s   = {REG_AW{1'b0}};
        assign skid_ops_s  = {OPS_W{1'b0}};
        assign skid_ctrl_s = {CTRL_W{1'b0}};
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = main_valid_r;
    assign bus.occupancy = {1'b0, main_valid_r} + {1'b0, skid_valid_r};

endmodule
